// File: rtl/lcd_cfah_cmd_scheduler_if.sv
// Command-request bus between the LCD clients and the CFAH command scheduler.
// The slave side is the scheduler. The master side is the client/LCD-top side.
interface lcd_cfah_cmd_scheduler_if;
    logic       i_req_init;
    logic       i_req_clear;
    logic       i_req_display_ctrl;
    logic       i_req_update_cgram;
    logic       i_req_update_lcd;
    logic       i_upd_all_char;
    logic       i_upd_line_sel;
    logic [3:0] i_upd_char_pos;
    logic       i_control_done;

    logic       o_start_init;
    logic       o_clear_display_cmd;
    logic       o_display_ctrl_cmd;
    logic       o_update_cgram;
    logic       o_update_lcd;
    logic       o_lcd_all_char;
    logic       o_lcd_line_sel;
    logic [3:0] o_lcd_char_position;
    logic       o_busy;
    logic       o_init_done;
    logic       o_timeout_err;
    logic [4:0] o_pending;

    modport slave (
        input  i_req_init, i_req_clear, i_req_display_ctrl, i_req_update_cgram,
               i_req_update_lcd, i_upd_all_char, i_upd_line_sel, i_upd_char_pos,
               i_control_done,
        output o_start_init, o_clear_display_cmd, o_display_ctrl_cmd, o_update_cgram,
               o_update_lcd, o_lcd_all_char, o_lcd_line_sel, o_lcd_char_position,
               o_busy, o_init_done, o_timeout_err, o_pending
    );

    modport master (
        output i_req_init, i_req_clear, i_req_display_ctrl, i_req_update_cgram,
               i_req_update_lcd, i_upd_all_char, i_upd_line_sel, i_upd_char_pos,
               i_control_done,
        input  o_start_init, o_clear_display_cmd, o_display_ctrl_cmd, o_update_cgram,
               o_update_lcd, o_lcd_all_char, o_lcd_line_sel, o_lcd_char_position,
               o_busy, o_init_done, o_timeout_err, o_pending
    );
endinterface

// File: rtl/lcd_cfah_cmd_scheduler.sv
// LCD CFAH command scheduler. It latches one-cycle client requests into pending bits.
// Requests are granted one at a time by fixed priority (init > clear > dctrl > cgram > lcd).
// Each grant emits a 1-cycle start pulse and then waits for the LCD top's done pulse.
// The wait is guarded by a timeout, and an idle gap follows every completion or abort.
module lcd_cfah_cmd_scheduler #(
    parameter int G_AUTO_INIT      = 1,
    parameter int G_TIMEOUT_CYCLES = 2**20,
    parameter int G_GAP_CYCLES     = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    lcd_cfah_cmd_scheduler_if.slave    bus
);
    localparam int CW = $clog2(G_TIMEOUT_CYCLES + 1);
    localparam int GW = $clog2(G_GAP_CYCLES + 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(G_TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] TO_MAX   = CW'(G_TIMEOUT_CYCLES);
    localparam logic [GW-1:0] GAP_LAST = GW'(G_GAP_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_GAP} state_t;

    state_t        state_q;
    logic [4:0]    pend_q, pend_d;
    logic [4:0]    gnt_q;
    logic [4:0]    pulse_q;
    logic [CW-1:0] to_cnt_q;
    logic [GW-1:0] gap_cnt_q;
    logic          armed_q;       // low only in the first cycle after reset release
    logic          init_done_q;
    logic          timeout_err_q;
    logic          sh_all_q, sh_line_q;
    logic [3:0]    sh_pos_q;
    logic          lcd_all_q, lcd_line_q;
    logic [3:0]    lcd_pos_q;

    logic [4:0]    req, elig, sel;
    logic          grant_en;

    // Priority select over eligible pending bits; set wins over grant-clear
    always_comb begin
        req  = {bus.i_req_update_lcd, bus.i_req_update_cgram, bus.i_req_display_ctrl,
                bus.i_req_clear, bus.i_req_init};
        elig = pend_q & {{4{init_done_q}}, 1'b1};
        sel  = 5'b00000;
        if      (elig[0]) sel = 5'b00001;
        else if (elig[1]) sel = 5'b00010;
        else if (elig[2]) sel = 5'b00100;
        else if (elig[3]) sel = 5'b01000;
        else if (elig[4]) sel = 5'b10000;
        grant_en = (state_q == S_IDLE) && (sel != 5'b00000);
        pend_d   = (pend_q & ~(grant_en ? sel : 5'b00000)) | req;
        if (!armed_q && (G_AUTO_INIT != 0)) pend_d[0] = 1'b1;
    end

    // Scheduler FSM with pending/shadow capture and all registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            pend_q        <= '0;
            gnt_q         <= '0;
            pulse_q       <= '0;
            to_cnt_q      <= '0;
            gap_cnt_q     <= '0;
            armed_q       <= 1'b0;
            init_done_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            sh_all_q      <= 1'b0;
            sh_line_q     <= 1'b0;
            sh_pos_q      <= '0;
            lcd_all_q     <= 1'b0;
            lcd_line_q    <= 1'b0;
            lcd_pos_q     <= '0;
        end else begin
            armed_q <= 1'b1;
            pend_q  <= pend_d;
            pulse_q <= '0;
            if (bus.i_req_update_lcd) begin
                sh_all_q  <= bus.i_upd_all_char;
                sh_line_q <= bus.i_upd_line_sel;
                sh_pos_q  <= bus.i_upd_char_pos;
            end
            case (state_q)
                S_IDLE: if (grant_en) begin
                    state_q <= S_ISSUE;
                    gnt_q   <= sel;
                    pulse_q <= sel;
                    // re-init blocks everything else until it completes again
                    if (sel[0]) init_done_q <= 1'b0;
                    if (sel[4]) begin
                        lcd_all_q  <= sh_all_q;
                        lcd_line_q <= sh_line_q;
                        lcd_pos_q  <= sh_pos_q;
                    end
                end
                S_ISSUE: begin
                    // done is deliberately not sampled here
                    state_q  <= S_WAIT;
                    to_cnt_q <= '0;
                end
                S_WAIT: begin
                    if (bus.i_control_done) begin
                        state_q   <= S_GAP;
                        gap_cnt_q <= '0;
                        if (gnt_q[0]) init_done_q <= 1'b1;
                    end else if (to_cnt_q == TO_LAST) begin
                        state_q       <= S_GAP;
                        gap_cnt_q     <= '0;
                        timeout_err_q <= 1'b1;
                    end else if (to_cnt_q != TO_MAX) begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
                end
                S_GAP: begin
                    if (gap_cnt_q == GAP_LAST) state_q   <= S_IDLE;
                    else                       gap_cnt_q <= gap_cnt_q + 1'b1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.o_start_init        = pulse_q[0];
    assign bus.o_clear_display_cmd = pulse_q[1];
    assign bus.o_display_ctrl_cmd  = pulse_q[2];
    assign bus.o_update_cgram      = pulse_q[3];
    assign bus.o_update_lcd        = pulse_q[4];
    assign bus.o_lcd_all_char      = lcd_all_q;
    assign bus.o_lcd_line_sel      = lcd_line_q;
    assign bus.o_lcd_char_position = lcd_pos_q;
    assign bus.o_busy              = (state_q != S_IDLE);
    assign bus.o_init_done         = init_done_q;
    assign bus.o_timeout_err       = timeout_err_q;
    assign bus.o_pending           = pend_q;
endmodule

// File: tb/tb_lcd_cfah_cmd_scheduler.sv
// Directed bench for the LCD CFAH command scheduler (timeout 100, gap 4, auto-init).
module tb_lcd_cfah_cmd_scheduler;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   n;
    logic [4:0] which;

    always #5 clk = ~clk;

    lcd_cfah_cmd_scheduler_if bus();

    lcd_cfah_cmd_scheduler #(
        .G_AUTO_INIT(1), .G_TIMEOUT_CYCLES(100), .G_GAP_CYCLES(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    logic [4:0] pulses;
    assign pulses = {bus.o_update_lcd, bus.o_update_cgram, bus.o_display_ctrl_cmd,
                     bus.o_clear_display_cmd, bus.o_start_init};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Tick until any start pulse shows, bounded; n = edges taken
    task automatic wait_pulse(output int cnt, output logic [4:0] w);
        cnt = 0;
        w = 5'b0;
        while (cnt < 300) begin
            tick();
            cnt++;
            if (pulses != 5'b0) begin
                w = pulses;
                break;
            end
        end
    endtask

    // From the ISSUE cycle: enter WAIT_DONE, then deliver one done pulse
    task automatic complete();
        tick();
        bus.i_control_done = 1'b1;
        tick();
        bus.i_control_done = 1'b0;
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_pulses"}, {27'd0, pulses}, 32'd0);
        chk({tag, "_pend"}, {27'd0, bus.o_pending}, 32'd0);
        chk({tag, "_flags"}, {29'd0, bus.o_busy, bus.o_init_done, bus.o_timeout_err}, 32'd0);
        chk({tag, "_args"}, {26'd0, bus.o_lcd_all_char, bus.o_lcd_line_sel, bus.o_lcd_char_position}, 32'd0);
    endtask

    initial begin
        bus.i_req_init = 0; bus.i_req_clear = 0; bus.i_req_display_ctrl = 0;
        bus.i_req_update_cgram = 0; bus.i_req_update_lcd = 0; bus.i_upd_all_char = 0;
        bus.i_upd_line_sel = 0; bus.i_upd_char_pos = 4'h0; bus.i_control_done = 0;

        // T1: reset, auto-init
        repeat (3) tick();
        all_zero("rst");
        rst_n = 1'b1;
        tick();
        chk("autoinit_pend", {27'd0, bus.o_pending}, 32'h01);
        chk("autoinit_busy", {31'd0, bus.o_busy}, 32'd0);
        tick();
        chk("init_pulse_c2", {27'd0, pulses}, 32'h01);
        chk("init_busy", {31'd0, bus.o_busy}, 32'd1);
        chk("init_pend_clr", {27'd0, bus.o_pending}, 32'h00);
        // T2: update-LCD request before init done
        bus.i_req_update_lcd = 1; bus.i_upd_char_pos = 4'h7; bus.i_upd_line_sel = 1;
        tick();
        bus.i_req_update_lcd = 0; bus.i_upd_char_pos = 4'h0; bus.i_upd_line_sel = 0;
        chk("lcd_held_pend", {27'd0, bus.o_pending}, 32'h10);
        chk("init_pulse_1cyc", {27'd0, pulses}, 32'h00);
        repeat (48) tick();
        chk("init_done_early", {31'd0, bus.o_init_done}, 32'd0);
        bus.i_control_done = 1;
        tick();
        bus.i_control_done = 0;
        chk("init_done_set", {31'd0, bus.o_init_done}, 32'd1);
        chk("gap_busy", {31'd0, bus.o_busy}, 32'd1);
        repeat (4) tick();
        chk("idle_after_gap", {31'd0, bus.o_busy}, 32'd0);
        tick();
        chk("lcd_pulse", {27'd0, pulses}, 32'h10);
        chk("lcd_pos", {28'd0, bus.o_lcd_char_position}, 32'h7);
        chk("lcd_line", {31'd0, bus.o_lcd_line_sel}, 32'd1);
        chk("lcd_all", {31'd0, bus.o_lcd_all_char}, 32'd0);
        complete();
        repeat (4) tick();
        chk("idle_t3", {31'd0, bus.o_busy}, 32'd0);

        // T3: four requests in one cycle, priority order and exact gaps
        bus.i_req_clear = 1; bus.i_req_display_ctrl = 1; bus.i_req_update_cgram = 1;
        bus.i_req_update_lcd = 1; bus.i_upd_char_pos = 4'h3; bus.i_upd_all_char = 1;
        tick();
        bus.i_req_clear = 0; bus.i_req_display_ctrl = 0; bus.i_req_update_cgram = 0;
        bus.i_req_update_lcd = 0; bus.i_upd_char_pos = 4'h0; bus.i_upd_all_char = 0;
        chk("t3_pend", {27'd0, bus.o_pending}, 32'h1e);
        chk("lcd_args_stable", {28'd0, bus.o_lcd_char_position}, 32'h7);
        tick();
        chk("t3_clear", {27'd0, pulses}, 32'h02);
        chk("t3_pend2", {27'd0, bus.o_pending}, 32'h1c);
        complete();
        wait_pulse(n, which);
        chk("t3_dctrl", {27'd0, which}, 32'h04);
        chk("t3_gap1", n, 32'd5);
        complete();
        wait_pulse(n, which);
        chk("t3_cgram", {27'd0, which}, 32'h08);
        chk("t3_gap2", n, 32'd5);
        complete();
        wait_pulse(n, which);
        chk("t3_lcd", {27'd0, which}, 32'h10);
        chk("t3_gap3", n, 32'd5);
        chk("t3_lcd_pos", {28'd0, bus.o_lcd_char_position}, 32'h3);
        chk("t3_lcd_all", {31'd0, bus.o_lcd_all_char}, 32'd1);
        complete();
        repeat (5) tick();

        // T4: clear times out, dctrl issued after the gap
        bus.i_req_clear = 1;
        tick();
        bus.i_req_clear = 0;
        tick();
        chk("t4_clear", {27'd0, pulses}, 32'h02);
        tick();
        bus.i_req_display_ctrl = 1;
        tick();
        bus.i_req_display_ctrl = 0;
        repeat (98) tick();
        chk("t4_err_early", {31'd0, bus.o_timeout_err}, 32'd0);
        tick();
        chk("t4_err_set", {31'd0, bus.o_timeout_err}, 32'd1);
        chk("t4_init_kept", {31'd0, bus.o_init_done}, 32'd1);
        wait_pulse(n, which);
        chk("t4_dctrl", {27'd0, which}, 32'h04);
        chk("t4_gap", n, 32'd5);

        // T5: done during ISSUE only is ignored; cgram waits for the timeout
        bus.i_control_done = 1; bus.i_req_update_cgram = 1;
        tick();
        bus.i_control_done = 0; bus.i_req_update_cgram = 0;
        repeat (99) tick();
        chk("t5_still_wait", {27'd0, bus.o_pending}, 32'h08);
        chk("t5_busy", {31'd0, bus.o_busy}, 32'd1);
        tick();
        wait_pulse(n, which);
        chk("t5_cgram", {27'd0, which}, 32'h08);
        chk("t5_gap", n, 32'd5);

        // T6: async reset in WAIT_DONE with three bits pending
        bus.i_req_update_lcd = 1; bus.i_req_clear = 1; bus.i_req_display_ctrl = 1;
        tick();
        bus.i_req_update_lcd = 0; bus.i_req_clear = 0; bus.i_req_display_ctrl = 0;
        tick();
        chk("t6_pend", {27'd0, bus.o_pending}, 32'h16);
        rst_n = 1'b0;
        #1;
        all_zero("t6_async");
        tick();
        all_zero("t6_held");
        rst_n = 1'b1;
        tick();
        chk("t6_only_init", {27'd0, bus.o_pending}, 32'h01);
        tick();
        chk("t6_reinit", {27'd0, pulses}, 32'h01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
